// File: rtl/alu_result_sink_if.sv
// ALU result / writeback / condition bus between the ALU side and alu_result_sink.
// The slave modport is the sink's view; master is the ALU/regfile/control view.
interface alu_result_sink_if #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 3
) ();
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [3:0]        res_flags;
  logic [DEST_W-1:0] res_dest;
  logic              res_wb_en;
  logic [3:0]        flag_we;
  logic              stc;
  logic              cmc;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [DEST_W-1:0] wb_dest;
  logic [3:0]        flag_reg;
  logic              carry_out;
  logic              cond_req;
  logic [2:0]        cond_sel;
  logic              cond_valid;
  logic              cond_true;

  modport slave (
    input  res_valid, res_data, res_flags, res_dest, res_wb_en, flag_we, stc, cmc,
    input  wb_ready, cond_req, cond_sel,
    output res_ready, wb_valid, wb_data, wb_dest, flag_reg, carry_out, cond_valid, cond_true
  );

  modport master (
    output res_valid, res_data, res_flags, res_dest, res_wb_en, flag_we, stc, cmc,
    output wb_ready, cond_req, cond_sel,
    input  res_ready, wb_valid, wb_data, wb_dest, flag_reg, carry_out, cond_valid, cond_true
  );
endinterface

// File: rtl/alu_result_sink.sv
// Consumer of ALU results: masked flag register with carry ops, 2-entry writeback
// FIFO, and branch-condition evaluation against the forwarded next-state flags.
module alu_result_sink #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 3,
  parameter int DEPTH  = 2
) (
  input logic               clk,
  input logic               reset,
  alu_result_sink_if.slave  bus
);
  localparam int          ENTRY_W  = DATA_W + DEST_W;
  localparam logic [1:0]  FULL_CNT = 2'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;
  logic [1:0]         count_d;
  logic [3:0]         flags_q;
  logic [3:0]         flags_d;
  logic               cond_valid_q;
  logic               cond_true_q;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;

  function automatic logic cond_eval(input logic [2:0] sel, input logic [3:0] f);
    logic r;
    case (sel)
      3'd0:    r = ~f[0];
      3'd1:    r =  f[0];
      3'd2:    r = ~f[1];
      3'd3:    r =  f[1];
      3'd4:    r =  f[3];
      3'd5:    r = ~f[3];
      3'd6:    r =  f[2];
      3'd7:    r = ~f[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign accept_s = bus.res_valid & bus.res_ready;
  assign push_s   = accept_s & bus.res_wb_en;
  assign pop_s    = bus.wb_valid & bus.wb_ready;

  assign bus.res_ready  = (count_q < FULL_CNT);
  assign bus.wb_valid   = (count_q != 2'd0);
  assign bus.wb_data    = mem_q[rd_ptr_q][ENTRY_W-1:DEST_W];
  assign bus.wb_dest    = mem_q[rd_ptr_q][DEST_W-1:0];
  assign bus.flag_reg   = flags_q;
  assign bus.carry_out  = flags_q[1];
  assign bus.cond_valid = cond_valid_q;
  assign bus.cond_true  = cond_true_q;

  // Next-state flags: masked result write; carry from result beats stc, which beats cmc.
  always_comb begin
    flags_d = flags_q;
    if (accept_s) begin
      flags_d = (bus.flag_we & bus.res_flags) | (~bus.flag_we & flags_q);
    end else begin
      flags_d = flags_q;
    end
    if (accept_s && bus.flag_we[1]) begin
      flags_d[1] = bus.res_flags[1];
    end else if (bus.stc) begin
      flags_d[1] = 1'b1;
    end else if (bus.cmc) begin
      flags_d[1] = ~flags_q[1];
    end else begin
      flags_d[1] = flags_q[1];
    end
  end

  // FIFO occupancy update.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers: FIFO, flags and condition result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      flags_q      <= 4'b0000;
      cond_valid_q <= 1'b0;
      cond_true_q  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {bus.res_data, bus.res_dest};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q      <= count_d;
      flags_q      <= flags_d;
      cond_valid_q <= bus.cond_req;
      if (bus.cond_req) begin
        cond_true_q <= cond_eval(bus.cond_sel, flags_d);
      end
    end
  end
endmodule

// File: tb/tb_alu_result_sink.sv
// Directed self-checking bench for alu_result_sink with hand-computed expectations.
module tb_alu_result_sink;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [7:0] sweep_exp;

  alu_result_sink_if #(.DATA_W(8), .DEST_W(3)) bus ();

  alu_result_sink #(.DATA_W(8), .DEST_W(3), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic v, input logic [7:0] d, input logic [2:0] dst,
                           input logic [3:0] fl, input logic [3:0] we, input logic wb_en);
    bus.res_valid = v;
    bus.res_data  = d;
    bus.res_dest  = dst;
    bus.res_flags = fl;
    bus.flag_we   = we;
    bus.res_wb_en = wb_en;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    sweep_exp = 8'b1001_1001;
    reset = 1'b1;
    drive_res(1'b0, 8'h00, 3'd0, 4'h0, 4'h0, 1'b0);
    bus.stc = 1'b0; bus.cmc = 1'b0; bus.wb_ready = 1'b0;
    bus.cond_req = 1'b0; bus.cond_sel = 3'd0;
    tick(); tick();
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_flags", 32'(bus.flag_reg), 32'h0);
    check("rst_cond_valid", 32'(bus.cond_valid), 32'd0);
    check("rst_wb_data", 32'(bus.wb_data), 32'h0);
    reset = 1'b0;
    tick();
    check("rst_res_ready", 32'(bus.res_ready), 32'd1);

    // Single result
    bus.wb_ready = 1'b1;
    drive_res(1'b1, 8'h5A, 3'd3, 4'b0100, 4'hF, 1'b1);
    tick();
    drive_res(1'b0, 8'h00, 3'd0, 4'h0, 4'h0, 1'b0);
    check("single_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("single_wb_data", 32'(bus.wb_data), 32'h5A);
    check("single_wb_dest", 32'(bus.wb_dest), 32'd3);
    check("single_flags", 32'(bus.flag_reg), 32'b0100);
    tick();
    check("single_popped", 32'(bus.wb_valid), 32'd0);

    // Backpressure: three back-to-back results, flags untouched
    bus.wb_ready = 1'b0;
    drive_res(1'b1, 8'h01, 3'd1, 4'h0, 4'h0, 1'b1);
    tick();
    check("bp_ready_after1", 32'(bus.res_ready), 32'd1);
    drive_res(1'b1, 8'h02, 3'd2, 4'h0, 4'h0, 1'b1);
    tick();
    check("bp_ready_after2", 32'(bus.res_ready), 32'd0);
    drive_res(1'b1, 8'h03, 3'd5, 4'h0, 4'h0, 1'b1);
    tick();
    check("bp_held_ready", 32'(bus.res_ready), 32'd0);
    check("bp_head01", 32'(bus.wb_data), 32'h01);
    check("bp_dest01", 32'(bus.wb_dest), 32'd1);
    bus.wb_ready = 1'b1;
    tick();
    check("bp_head02", 32'(bus.wb_data), 32'h02);
    check("bp_ready_drain", 32'(bus.res_ready), 32'd1);
    tick();
    drive_res(1'b0, 8'h00, 3'd0, 4'h0, 4'h0, 1'b0);
    check("bp_head03", 32'(bus.wb_data), 32'h03);
    check("bp_dest03", 32'(bus.wb_dest), 32'd5);
    check("bp_valid03", 32'(bus.wb_valid), 32'd1);
    tick();
    check("bp_empty", 32'(bus.wb_valid), 32'd0);
    check("bp_flags_kept", 32'(bus.flag_reg), 32'b0100);

    // Compare-only result
    drive_res(1'b1, 8'hEE, 3'd7, 4'b0011, 4'b0011, 1'b0);
    tick();
    drive_res(1'b0, 8'h00, 3'd0, 4'h0, 4'h0, 1'b0);
    check("cmp_no_push", 32'(bus.wb_valid), 32'd0);
    check("cmp_flags", 32'(bus.flag_reg), 32'b0111);
    check("cmp_carry_out", 32'(bus.carry_out), 32'd1);

    // Carry operations
    bus.cmc = 1'b1;
    tick();
    check("cmc_clear", 32'(bus.flag_reg), 32'b0101);
    bus.stc = 1'b1;
    tick();
    check("stc_over_cmc", 32'(bus.flag_reg), 32'b0111);
    bus.stc = 1'b0;
    tick();
    check("cmc_again", 32'(bus.carry_out), 32'd0);
    drive_res(1'b1, 8'h00, 3'd0, 4'b0010, 4'b0010, 1'b0);
    tick();
    bus.cmc = 1'b0;
    drive_res(1'b0, 8'h00, 3'd0, 4'h0, 4'h0, 1'b0);
    check("accept_over_cmc", 32'(bus.flag_reg), 32'b0111);

    // Condition forwarding
    drive_res(1'b1, 8'h00, 3'd0, 4'b0000, 4'hF, 1'b0);
    tick();
    drive_res(1'b1, 8'h00, 3'd0, 4'b0001, 4'b0001, 1'b0);
    bus.cond_req = 1'b1; bus.cond_sel = 3'd1;
    tick();
    drive_res(1'b0, 8'h00, 3'd0, 4'h0, 4'h0, 1'b0);
    bus.cond_req = 1'b0;
    check("fwd_cond_valid", 32'(bus.cond_valid), 32'd1);
    check("fwd_cond_true", 32'(bus.cond_true), 32'd1);
    check("fwd_flags", 32'(bus.flag_reg), 32'b0001);
    tick();
    check("cond_valid_drop", 32'(bus.cond_valid), 32'd0);

    // Sweep all codes against flags 1010
    drive_res(1'b1, 8'h00, 3'd0, 4'b1010, 4'hF, 1'b0);
    tick();
    drive_res(1'b0, 8'h00, 3'd0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.cond_req = 1'b1; bus.cond_sel = 3'(i);
      tick();
      check($sformatf("sweep_sel%0d", i), 32'(bus.cond_true), 32'(sweep_exp[i]));
      check($sformatf("sweep_valid%0d", i), 32'(bus.cond_valid), 32'd1);
    end
    bus.cond_req = 1'b0;

    // Reset mid-stream with two entries buffered and a condition pending
    bus.wb_ready = 1'b0;
    drive_res(1'b1, 8'hA1, 3'd1, 4'h0, 4'h0, 1'b1);
    tick();
    drive_res(1'b1, 8'hA2, 3'd2, 4'h0, 4'h0, 1'b1);
    bus.cond_req = 1'b1;
    tick();
    drive_res(1'b0, 8'h00, 3'd0, 4'h0, 4'h0, 1'b0);
    bus.cond_req = 1'b0;
    check("pre_rst_full", 32'(bus.res_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("mid_rst_flags", 32'(bus.flag_reg), 32'h0);
    check("mid_rst_cond_valid", 32'(bus.cond_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(bus.res_ready), 32'd1);
    check("post_rst_wb_valid", 32'(bus.wb_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_sink.md
Name: alu_result_sink

Overview:
- Consumer side of the 8-bit ALU result interface.
- Accepts each ALU result (8-bit data, 4-bit flag array, destination register index) with a valid/ready handshake.
- Updates the architectural flag register under a per-bit write mask, buffers results in a 2-entry FIFO toward register-file writeback, and feeds the stored carry back to the ALU carry input.
- Evaluates the 8 conditional-branch conditions for the control unit from the flag register.

Parameters:
- DATA_W, 8, result data width.
- DEST_W, 3, destination register index width.
- DEPTH, 2, writeback FIFO depth (fixed at 2; other values unsupported).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- res_valid  input  1  ALU result present.
- res_ready  output  1  sink can accept result.
- res_data  input  DATA_W  ALU Out.
- res_flags  input  4  ALU flag array {OddParity, Positive, Cout, Zero} = bits [3:0].
- res_dest  input  DEST_W  destination register index.
- res_wb_en  input  1  result is written to register file (0 = flags only, e.g. compare).
- flag_we  input  4  per-bit flag write mask, same bit order as res_flags.
- stc  input  1  set-carry pulse.
- cmc  input  1  complement-carry pulse.
- wb_valid  output  1  writeback entry available.
- wb_ready  input  1  register file accepts entry.
- wb_data  output  DATA_W  writeback data.
- wb_dest  output  DEST_W  writeback register index.
- flag_reg  output  4  architectural flags.
- carry_out  output  1  flag_reg[1], drives ALU Cin.
- cond_req  input  1  condition evaluation request.
- cond_sel  input  3  condition code.
- cond_valid  output  1  condition result valid.
- cond_true  output  1  condition result.

Behaviour:
- Reset (asynchronous, active-high):
  - flag_reg = 4'b0000; FIFO empties (count = 0).
  - wb_valid = 0, wb_data = 0, wb_dest = 0, cond_valid = 0, cond_true = 0.
  - Reset asserted mid-operation discards buffered entries and any pending condition result.
- Accept: accept = res_valid & res_ready.
- res_ready = (count < 2), combinational from registered count. res_ready = 1 out of reset.
- On accept with res_wb_en = 1: push {res_data, res_dest}.
- On accept with res_wb_en = 0: no push; flags still update.
- Pop: when wb_valid & wb_ready.
- wb_valid = (count != 0). wb_data and wb_dest present the head entry. No combinational path from res_* to wb_*; minimum latency is 1 cycle.
- Push and pop in the same cycle at count = 1: count stays 1, ordering preserved.
- At count = 2, res_ready = 0, so a push cannot coincide with full.
- Pop at count = 0 is impossible (wb_valid = 0).
- Flag update on accept: flag_reg[i] <= flag_we[i] ? res_flags[i] : flag_reg[i].
- Carry priority, highest first:
  1. accept with flag_we[1] = 1.
  2. stc (carry <= 1; stc wins over cmc if both asserted).
  3. cmc (carry <= ~carry).
- stc/cmc never touch bits 3, 2, 0.
- Condition evaluation: cond_req sampled at clk; cond_valid = 1 and cond_true registered on the next edge (1-cycle latency). cond_valid deasserts the cycle after, unless cond_req is held.
- Evaluation uses the flag value being written that same edge (forwarded next-state flags), so a branch issued in the same cycle as its flag-setting result sees the new flags.
- cond_sel codes:
  - 0 NZ: Z = 0.
  - 1 Z: Z = 1.
  - 2 NC: CY = 0.
  - 3 C: CY = 1.
  - 4 PO: OddParity = 1.
  - 5 PE: OddParity = 0.
  - 6 P: Positive = 1.
  - 7 M: Positive = 0.
- carry_out equals flag_reg[1] at all times, so it changes exactly one edge after the update.

Test Plan:
- Reset: reset high mid-stream with 2 entries buffered -> immediately wb_valid = 0, flag_reg = 0, cond_valid = 0; after release res_ready = 1.
- Single result: res_data = 8'h5A, res_dest = 3, res_flags = 4'b0100, flag_we = 4'hF, wb_ready = 1 -> next cycle wb_valid = 1, wb_data = 8'h5A, wb_dest = 3, flag_reg = 4'b0100; entry popped; wb_valid = 0 the cycle after.
- Backpressure: wb_ready = 0, three back-to-back results 8'h01/02/03 -> res_ready drops after the 2nd accept, 3rd held. Releasing wb_ready drains 01, 02, 03 in order with no loss or duplication.
- Compare-only result: res_wb_en = 0, res_flags = 4'b0011, flag_we = 4'b0011 -> no FIFO push; flag_reg[1:0] = 2'b11, bits [3:2] unchanged; carry_out = 1.
- Carry ops: carry = 0, stc & cmc together -> carry = 1; then cmc alone -> 0. cmc in the same cycle as accept with flag_we[1] = 1 and Cout = 1 -> carry = 1.
- Condition forwarding: accept with Z = 1 (flag_we[0] = 1) and cond_req with cond_sel = 1 in the same cycle -> next cycle cond_valid = 1, cond_true = 1. Sweep all 8 codes against flag_reg = 4'b1010 -> expected cond_true pattern NZ = 1, Z = 0, NC = 0, C = 1, PO = 1, PE = 0, P = 0, M = 1.
